// File: rtl/tag_lookup_ctrl.sv
// Tag RAM initiator: lookup with one-cycle synchronous read, optional fill on miss,
// and a full-array invalidating flush.
module tag_lookup_ctrl #(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 13
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AWIDTH-1:0] req_index,
  input  logic [TWIDTH-1:0] req_tag,
  input  logic              req_fill,
  output logic              rsp_valid,
  output logic              rsp_hit,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic              flush_done,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [TWIDTH:0]   ram_din,
  output logic              ram_we,
  input  logic [TWIDTH:0]   ram_dout
);

  localparam int DEPTH = 1 << AWIDTH;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOOKUP  = 3'd1;
  localparam logic [2:0] COMPARE = 3'd2;
  localparam logic [2:0] FILL    = 3'd3;
  localparam logic [2:0] FLUSH   = 3'd4;

  logic [2:0]        state;
  logic              flush_pend;
  logic [AWIDTH-1:0] cnt;
  logic [AWIDTH-1:0] idx_q;
  logic [TWIDTH-1:0] tag_q;
  logic              fill_q;
  logic              hit;
  logic              last_flush;

  // An entry with a matching tag but a cleared valid bit is a miss.
  assign hit        = ram_dout[TWIDTH] && (ram_dout[TWIDTH-1:0] == tag_q);
  assign last_flush = (state == FLUSH) && (cnt == AWIDTH'(DEPTH - 1));
  assign req_ready  = (state == IDLE) && !flush_pend;
  assign flush_busy = flush_pend;

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = idx_q;
    ram_din  = '0;
    case (state)
      FILL: begin
        ram_we  = 1'b1;
        ram_din = {1'b1, tag_q};
      end
      FLUSH: begin
        ram_we   = 1'b1;
        ram_addr = cnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
      cnt        <= '0;
      idx_q      <= '0;
      tag_q      <= '0;
      fill_q     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      rsp_valid  <= 1'b0;
      flush_done <= 1'b0;
      // Clearing on the last flush write wins, so a late flush_req is absorbed.
      if (last_flush)     flush_pend <= 1'b0;
      else if (flush_req) flush_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (flush_pend) begin
            state <= FLUSH;
            cnt   <= '0;
          end else if (req_valid) begin
            idx_q  <= req_index;
            tag_q  <= req_tag;
            fill_q <= req_fill;
            state  <= LOOKUP;
          end
        end
        LOOKUP:  state <= COMPARE;
        COMPARE: begin
          rsp_valid <= 1'b1;
          rsp_hit   <= hit;
          state     <= (!hit && fill_q) ? FILL : IDLE;
        end
        FILL:    state <= IDLE;
        FLUSH: begin
          cnt <= cnt + 1'b1;
          if (last_flush) begin
            state      <= IDLE;
            flush_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Bench for tag_lookup_ctrl: transaction-scheduled reference model plus bench-side tag RAM.
module tb_tag_lookup_ctrl;
  localparam int AW = 3;
  localparam int TW = 13;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_index = '0;
  logic [TW-1:0] req_tag = '0;
  logic          req_fill = 1'b0;
  logic          rsp_valid, rsp_hit;
  logic          flush_req = 1'b0;
  logic          flush_busy, flush_done;
  logic [AW-1:0] ram_addr;
  logic [TW:0]   ram_din;
  logic          ram_we;
  logic [TW:0]   ram_dout;

  tag_lookup_ctrl #(.AWIDTH(AW), .TWIDTH(TW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_tag(req_tag), .req_fill(req_fill),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clock = ~clock;

  function automatic logic [TW:0] init_word(input int i);
    case (i)
      1:       return {1'b1, 13'h077};
      2:       return {1'b1, 13'h0AB};
      5:       return 14'h0;
      6:       return {1'b0, 13'h055};
      default: return {1'b1, 13'(i)};
    endcase
  endfunction

  // Bench-side synchronous-read tag RAM, preloaded on the first edge (reset is low then).
  logic [TW:0] ram [8];
  logic        pre_done = 1'b0;
  always @(posedge clock) begin
    if (!pre_done) begin
      for (int i = 0; i < 8; i++) ram[i] <= init_word(i);
      pre_done <= 1'b1;
    end else if (ram_we) begin
      ram[ram_addr] <= ram_din;
    end
    ram_dout <= ram[ram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: schedules of expected outputs keyed by cycle index
  // (the cycle that follows edge number j).
  int          ec = 0;
  logic [TW:0] mmem [8];
  bit          s_we   [int];
  logic [AW-1:0] s_addr [int];
  logic [TW:0] s_din  [int];
  bit          s_rsp  [int];
  bit          s_done [int];
  int          a_next = 0;
  bit          pend = 1'b0, flushing = 1'b0, pend_old, end_now, mhit;
  int          fl_start = 0, fl_end = 0;
  logic [AW-1:0] m_idx = '0;
  int          m_acc_cnt = 0, m_acc_edge = 0;

  initial begin
    for (int i = 0; i < 8; i++) mmem[i] = init_word(i);
    forever begin
      @(posedge clock);
      ec++;
      if (!reset_n) begin
        s_we.delete(); s_addr.delete(); s_din.delete(); s_rsp.delete(); s_done.delete();
        a_next = 0; pend = 0; flushing = 0; m_idx = '0;
      end else begin
        if (s_we.exists(ec - 1)) mmem[s_addr[ec-1]] = s_din[ec-1];
        pend_old = pend;
        end_now  = flushing && (ec == fl_end);
        if (ec >= a_next) begin
          if (pend_old) begin
            flushing = 1; fl_start = ec; fl_end = ec + 8; a_next = ec + 9;
            for (int i = 0; i < 8; i++) begin
              s_we[ec+i] = 1; s_addr[ec+i] = AW'(i); s_din[ec+i] = '0;
            end
            s_done[ec+8] = 1;
          end else if (req_valid) begin
            mhit = mmem[req_index][TW] && (mmem[req_index][TW-1:0] == req_tag);
            m_idx = req_index; m_acc_cnt++; m_acc_edge = ec;
            s_rsp[ec+2] = mhit;
            if (!mhit && req_fill) begin
              s_we[ec+2] = 1; s_addr[ec+2] = req_index; s_din[ec+2] = {1'b1, req_tag};
              a_next = ec + 4;
            end else begin
              a_next = ec + 3;
            end
          end
        end
        if (end_now) begin pend = 0; flushing = 0; end
        else if (flush_req) pend = 1;
      end
    end
  end

  int we_seen = 0, done_seen = 0;
  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        chk("rst_we", 32'(ram_we), 0);
        chk("rst_addr", 32'(ram_addr), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_flush_done", 32'(flush_done), 0);
        chk("rst_flush_busy", 32'(flush_busy), 0);
      end else begin
        chk("ram_we", 32'(ram_we), 32'(s_we.exists(ec)));
        chk("ram_addr", 32'(ram_addr), s_we.exists(ec) ? 32'(s_addr[ec]) : 32'(m_idx));
        chk("ram_din", 32'(ram_din), s_we.exists(ec) ? 32'(s_din[ec]) : 0);
        chk("rsp_valid", 32'(rsp_valid), 32'(s_rsp.exists(ec)));
        if (s_rsp.exists(ec)) chk("rsp_hit", 32'(rsp_hit), 32'(s_rsp[ec]));
        chk("req_ready", 32'(req_ready), 32'((ec + 1 >= a_next) && !pend));
        chk("flush_busy", 32'(flush_busy), 32'(pend));
        chk("flush_done", 32'(flush_done), 32'(s_done.exists(ec)));
      end
      if (ram_we) we_seen++;
      if (flush_done) done_seen++;
    end
  end

  task automatic sync();
    @(posedge clock); #2;
  endtask

  task automatic at_cycle(input int j);
    while (ec < j) begin @(posedge clock); #1; end
    @(negedge clock);
  endtask

  task automatic do_req(input logic [AW-1:0] i, input logic [TW-1:0] t, input logic f,
                        output int e0);
    int  c0;
    bit  got;
    c0 = m_acc_cnt; got = 0;
    req_valid = 1; req_index = i; req_tag = t; req_fill = f;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clock); #1;
      if (m_acc_cnt != c0) got = 1;
    end
    #1;
    req_valid = 0;
    e0 = m_acc_edge;
    chk("req_accept_timeout", 32'(got), 1);
  endtask

  int e0, e1, w0, d0;
  bit reached;
  initial begin
    repeat (2) @(posedge clock);
    #3 reset_n = 1;
    sync();
    chk("lit_ready_after_reset", 32'(req_ready), 1);
    chk("lit_we_after_reset", 32'(ram_we), 0);
    chk("lit_addr_after_reset", 32'(ram_addr), 0);

    // Hit on a preloaded valid entry, no write.
    w0 = we_seen;
    do_req(3'd2, 13'h0AB, 1'b1, e0);
    at_cycle(e0 + 1);
    chk("lit_t1_early_rsp", 32'(rsp_valid), 0);
    at_cycle(e0 + 2);
    chk("lit_t1_rsp_valid", 32'(rsp_valid), 1);
    chk("lit_t1_rsp_hit", 32'(rsp_hit), 1);
    sync(); sync();
    chk("lit_t1_no_write", 32'(we_seen - w0), 0);

    // Fill on an invalid entry, then the repeat hits.
    do_req(3'd5, 13'h123, 1'b1, e0);
    at_cycle(e0 + 2);
    chk("lit_t2_rsp_hit", 32'(rsp_hit), 0);
    chk("lit_t2_we", 32'(ram_we), 1);
    chk("lit_t2_addr", 32'(ram_addr), 5);
    chk("lit_t2_din", 32'(ram_din), 32'h2123);
    sync();
    do_req(3'd5, 13'h123, 1'b0, e1);
    chk("lit_t2_accept_edge", 32'(e1 - e0), 4);
    at_cycle(e1 + 2);
    chk("lit_t2_repeat_hit", 32'(rsp_hit), 1);
    sync();

    // No-fill miss and valid=0 with matching tag.
    w0 = we_seen;
    do_req(3'd1, 13'h078, 1'b0, e0);
    at_cycle(e0 + 2);
    chk("lit_t3_miss", 32'(rsp_hit), 0);
    sync();
    do_req(3'd6, 13'h055, 1'b0, e0);
    at_cycle(e0 + 2);
    chk("lit_t3_invalid_miss", 32'(rsp_hit), 0);
    sync(); sync();
    chk("lit_t3_no_write", 32'(we_seen - w0), 0);

    // Flush from IDLE.
    w0 = we_seen; d0 = done_seen;
    flush_req = 1; sync(); flush_req = 0;
    repeat (12) sync();
    chk("lit_t4_flush_writes", 32'(we_seen - w0), 8);
    chk("lit_t4_flush_done", 32'(done_seen - d0), 1);
    chk("lit_t4_busy_low", 32'(flush_busy), 0);
    for (int i = 0; i < 8; i++) begin
      do_req(AW'(i), 13'h0AB, 1'b0, e0);
      at_cycle(e0 + 2);
      chk("lit_t4_post_flush_miss", 32'(rsp_hit), 0);
      sync();
    end

    // flush_req on the accepting edge of a fill-miss.
    flush_req = 1;
    do_req(3'd3, 13'h044, 1'b1, e0);
    flush_req = 0;
    at_cycle(e0 + 2);
    chk("lit_t5_rsp_hit", 32'(rsp_hit), 0);
    chk("lit_t5_fill_addr", 32'(ram_addr), 3);
    at_cycle(e0 + 3);
    chk("lit_t5_ready_low", 32'(req_ready), 0);
    chk("lit_t5_busy", 32'(flush_busy), 1);
    at_cycle(e0 + 4);
    chk("lit_t5_flush_first_we", 32'(ram_we), 1);
    chk("lit_t5_flush_first_addr", 32'(ram_addr), 0);
    at_cycle(e0 + 12);
    chk("lit_t5_flush_done", 32'(flush_done), 1);
    sync();

    // Refill everything, then reset in the middle of a flush at cnt=3.
    for (int i = 0; i < 8; i++) begin
      do_req(AW'(i), 13'h100 + 13'(i), 1'b1, e0);
      sync(); sync(); sync();
    end
    flush_req = 1; sync(); flush_req = 0;
    reached = 0;
    for (int k = 0; k < 40 && !reached; k++) begin
      if (flushing && ec == fl_start + 3) reached = 1;
      else begin @(posedge clock); #1; end
    end
    chk("flush_cnt3_timeout", 32'(reached), 1);
    d0 = done_seen;
    #2 reset_n = 0;
    #1;
    chk("lit_t6_we_in_reset", 32'(ram_we), 0);
    chk("lit_t6_addr_in_reset", 32'(ram_addr), 0);
    @(posedge clock);
    #3 reset_n = 1;
    sync();
    chk("lit_t6_ready_after", 32'(req_ready), 1);
    for (int i = 0; i < 8; i++) begin
      do_req(AW'(i), 13'h100 + 13'(i), 1'b0, e0);
      at_cycle(e0 + 2);
      chk("lit_t6_partial_flush_hit", 32'(rsp_hit), 32'(i >= 3));
      sync();
    end
    chk("lit_t6_no_flush_done", 32'(done_seen - d0), 0);

    // Randomized traffic with occasional flushes.
    for (int k = 0; k < 600; k++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_index = AW'($urandom_range(0, 7));
      req_tag   = 13'h100 + 13'($urandom_range(0, 3));
      req_fill  = 1'($urandom_range(0, 1));
      flush_req = ($urandom_range(0, 39) == 0);
      sync();
    end
    req_valid = 0; flush_req = 0;
    repeat (20) sync();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tag_lookup_ctrl.md
# tag_lookup_ctrl

Initiator-side controller for the synchronous-read tag RAM (AWIDTH=3, DWIDTH=14 words of {valid, tag}). Accepts lookup requests, drives the RAM address, waits out the one-cycle read latency, compares the stored tag, and reports hit/miss. It optionally allocates the entry on a miss. It also runs a full-array flush that invalidates every entry. It sits between the cache access logic and the tag RAM instance, and is the only agent driving the RAM's addr/din/we.

## Interface
- AWIDTH, 3, index width; DEPTH = 1 << AWIDTH entries
- TWIDTH, 13, tag width; RAM word width DWIDTH = TWIDTH+1, bit [TWIDTH] = valid, bits [TWIDTH-1:0] = tag

- clock  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  lookup request present
- req_ready  out  1  controller can accept; = (state==IDLE) && !flush_pend
- req_index  in  AWIDTH  set index
- req_tag  in  TWIDTH  tag to compare
- req_fill  in  1  on miss, write {1, req_tag} to req_index
- rsp_valid  out  1  one-cycle pulse, response valid
- rsp_hit  out  1  hit result, qualified by rsp_valid
- flush_req  in  1  pulse; request invalidation of all entries
- flush_busy  out  1  high while flush pending or running
- flush_done  out  1  one-cycle pulse after last flush write
- ram_addr  out  AWIDTH  to RAM addr
- ram_din  out  TWIDTH+1  to RAM din
- ram_we  out  1  to RAM we
- ram_dout  in  TWIDTH+1  from RAM dout (valid one cycle after address is latched)

## Operation
- States: IDLE, LOOKUP, COMPARE, FILL, FLUSH.
- IDLE: if flush_pend, go to FLUSH with cnt=0. Else if req_valid && req_ready, capture index/tag/fill into idx_q/tag_q/fill_q and go to LOOKUP.
- LOOKUP: ram_addr=idx_q, ram_we=0. The RAM latches the address at the end of this cycle. Next state is COMPARE.
- COMPARE: hit = ram_dout[TWIDTH] && (ram_dout[TWIDTH-1:0]==tag_q). Register rsp_valid=1 and rsp_hit=hit. Next state is FILL if !hit && fill_q, else IDLE.
- FILL: ram_addr=idx_q, ram_din={1'b1, tag_q}, ram_we=1 for exactly one cycle. Next state is IDLE.
- FLUSH: ram_addr=cnt, ram_din=0, ram_we=1. cnt increments each cycle. On cnt==DEPTH-1, go to IDLE, clear flush_pend, and register flush_done=1. cnt is AWIDTH wide and wraps to 0.
- flush_pend: set by flush_req in any state and cleared on FLUSH exit. A flush_req arriving during FLUSH is absorbed, with no second pass.
- ram_we is 0 in every state except FILL and FLUSH. ram_addr = idx_q in IDLE/LOOKUP/COMPARE/FILL and cnt in FLUSH. ram_din = 0 except in FILL.
- Hit with req_fill=1: no write. Entry with matching tag but valid=0 is a miss.
- Reset (async, any state): state=IDLE, flush_pend=0, cnt=0, idx_q/tag_q/fill_q=0, rsp_valid=0, rsp_hit=0, flush_done=0. ram_we is 0 immediately and ram_addr is 0. req_ready=1 after reset release. A flush in progress is abandoned, not resumed. RAM contents are untouched by reset.

## Timing
- Edge E0 accepts the request. LOOKUP runs in cycle E0–E1. COMPARE runs in E1–E2. rsp_valid is high for exactly the cycle after E2, so response latency is 2 edges after acceptance.
- Fill write is committed at E3. The next request can be accepted at E3 on a hit or no-fill miss, or at E4 after a fill. Sustained throughput is 1 request per 3 cycles.
- flush_req and an accepted request on the same edge: the request completes first (including FILL), then FLUSH starts.
- Flush duration: DEPTH write cycles. flush_done pulses the cycle after the last write. flush_busy stays high from the edge after flush_req until flush_done.
- req_ready has no combinational path from req_valid or flush_req.

## Test plan
- Reset then lookup index 2, tag 0x0AB against an entry initialised to {1, 0x0AB} -> rsp_valid 2 edges after acceptance, rsp_hit=1, ram_we never asserted.
- Lookup index 5, tag 0x123, req_fill=1 on an invalid entry -> rsp_hit=0, one ram_we pulse with ram_addr=5 and ram_din=0x2123. A repeat lookup then hits.
- Miss with req_fill=0 -> rsp_hit=0, no write. A stored tag matching but valid=0 -> miss.
- flush_req pulse in IDLE -> ram_we high for 8 consecutive cycles with addresses 0..7 and din=0, then flush_done one pulse, flush_busy low. All subsequent lookups miss.
- flush_req asserted on the same edge a fill-miss request is accepted -> response and fill complete first, then the flush. req_ready stays low throughout.
- reset_n asserted at flush cnt=3 -> outputs reset immediately, entries 0..2 cleared and entries 3..7 retain their contents, no flush_done, req_ready=1 after release.
